// File: rtl/s_term_loopback_checker.sv
// South-edge loopback BIST: drives LFSR words north and checks the
// bit-reversed reflection returning south after a programmable latency.
module s_term_loopback_checker #(
    parameter logic [35:0] SEED         = 36'h0_0000_0001,
    parameter int          NUM_PATTERNS = 1024,
    parameter int          MAX_LAT      = 8,
    parameter int          ERR_CNT_W    = 16
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [3:0]           lat_cfg,
    output logic [3:0]           N1BEG,
    output logic [7:0]           N2BEG,
    output logic [7:0]           N2BEGb,
    output logic [15:0]          N4BEG,
    input  logic [3:0]           S1END,
    input  logic [7:0]           S2MID,
    input  logic [7:0]           S2END,
    input  logic [15:0]          S4END,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [15:0]          first_err_pat,
    output logic [5:0]           first_err_bit
);

    localparam logic [35:0] SEED_EFF = (SEED == 36'd0) ? 36'd1 : SEED;
    localparam int LW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [15:0] NUM_P = 16'(NUM_PATTERNS);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [35:0] lfsr_step(input logic [35:0] v);
        return {v[34:0], v[35] ^ v[24]};
    endfunction

    state_t               r_state;
    logic [35:0]          r_lfsr;
    logic [35:0]          r_tx;
    logic                 r_tx_v;
    logic [35:0]          r_dl_d [MAX_LAT];
    logic [MAX_LAT-1:0]   r_dl_v;
    logic [LW-1:0]        r_lat_m1;
    logic [15:0]          r_iss_cnt;
    logic [15:0]          r_chk_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [15:0]          r_first_pat;
    logic [5:0]           r_first_bit;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;

    logic [35:0]          w_rx;
    logic [35:0]          w_exp;
    logic [35:0]          w_diff;
    logic                 w_active;
    logic                 w_mis;
    logic [5:0]           w_bit;
    logic [ERR_CNT_W-1:0] w_err_nxt;
    logic [15:0]          w_chk_nxt;
    logic [LW-1:0]        w_lat_m1;

    // Undo the index reversal of the reflection so rx lines up with tx bits
    always_comb begin
        w_rx = '0;
        for (int i = 0; i < 4; i++) w_rx[i] = S1END[3-i];
        for (int i = 0; i < 8; i++) begin
            w_rx[4+i]  = S2MID[7-i];
            w_rx[12+i] = S2END[7-i];
        end
        for (int i = 0; i < 16; i++) w_rx[20+i] = S4END[15-i];
    end

    always_comb begin
        w_lat_m1 = '0;
        if (lat_cfg == 4'd0)
            w_lat_m1 = '0;
        else if (int'(lat_cfg) > MAX_LAT)
            w_lat_m1 = LW'(MAX_LAT - 1);
        else
            w_lat_m1 = LW'(lat_cfg - 4'd1);
    end

    always_comb begin
        w_exp    = r_dl_d[r_lat_m1];
        w_active = (r_state == S_RUN || r_state == S_DRAIN)
                   && r_dl_v[r_lat_m1];
        w_diff   = w_rx ^ w_exp;
        w_mis    = w_active && (|w_diff);
        w_bit    = '0;
        for (int i = 35; i >= 0; i--)
            if (w_diff[i]) w_bit = 6'(i);
        w_err_nxt = r_err_cnt;
        if (w_mis && r_err_cnt != ERR_MAX)
            w_err_nxt = r_err_cnt + 1'b1;
        w_chk_nxt = r_chk_cnt + 16'(w_active);
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_lfsr      <= SEED_EFF;
            r_tx        <= '0;
            r_tx_v      <= 1'b0;
            for (int i = 0; i < MAX_LAT; i++) r_dl_d[i] <= '0;
            r_dl_v      <= '0;
            r_lat_m1    <= '0;
            r_iss_cnt   <= '0;
            r_chk_cnt   <= '0;
            r_err_cnt   <= '0;
            r_first_pat <= '0;
            r_first_bit <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_dl_d[0] <= r_tx;
            r_dl_v[0] <= r_tx_v;
            for (int i = 1; i < MAX_LAT; i++) begin
                r_dl_d[i] <= r_dl_d[i-1];
                r_dl_v[i] <= r_dl_v[i-1];
            end
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= '0;
                        r_first_pat <= '0;
                        r_first_bit <= '0;
                        r_iss_cnt   <= 16'd1;
                        r_chk_cnt   <= '0;
                        r_lat_m1    <= w_lat_m1;
                        r_tx        <= SEED_EFF;
                        r_tx_v      <= 1'b1;
                        r_lfsr      <= lfsr_step(SEED_EFF);
                        r_dl_v      <= '0;
                    end
                end
                S_RUN, S_DRAIN: begin
                    r_err_cnt <= w_err_nxt;
                    r_chk_cnt <= w_chk_nxt;
                    if (w_mis && r_err_cnt == '0) begin
                        r_first_pat <= r_chk_cnt;
                        r_first_bit <= w_bit;
                    end
                    if (r_state == S_RUN && r_iss_cnt != NUM_P) begin
                        r_tx      <= r_lfsr;
                        r_lfsr    <= lfsr_step(r_lfsr);
                        r_iss_cnt <= r_iss_cnt + 16'd1;
                    end else begin
                        r_tx   <= '0;
                        r_tx_v <= 1'b0;
                        if (r_state == S_RUN) r_state <= S_DRAIN;
                    end
                    if (w_chk_nxt == NUM_P) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                    end
                end
            endcase
        end
    end

    assign N1BEG         = r_tx[3:0];
    assign N2BEG         = r_tx[11:4];
    assign N2BEGb        = r_tx[19:12];
    assign N4BEG         = r_tx[35:20];
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_pat = r_first_pat;
    assign first_err_bit = r_first_bit;

endmodule

// File: tb/tb_s_term_loopback_checker.sv
// Directed bench for s_term_loopback_checker with a behavioural
// reflecting loopback of selectable delay and an optional stuck bit.
module tb_s_term_loopback_checker;

    localparam logic [35:0] SEED_A = 36'h9_A5C3_1E7B;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  lat_cfg = 4'd2;
    logic [3:0]  N1BEG;
    logic [7:0]  N2BEG, N2BEGb;
    logic [15:0] N4BEG;
    logic [3:0]  S1END;
    logic [7:0]  S2MID, S2END;
    logic [15:0] S4END;
    logic        busy, done, pass;
    logic [15:0] err_cnt, first_err_pat;
    logic [5:0]  first_err_bit;

    logic        start2 = 1'b0;
    logic [3:0]  N1BEG2;
    logic [7:0]  N2BEG2, N2BEGb2;
    logic [15:0] N4BEG2;
    logic        busy2, done2, pass2;
    logic [3:0]  err_cnt2;
    logic [15:0] first_err_pat2;
    logic [5:0]  first_err_bit2;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    s_term_loopback_checker #(
        .SEED(SEED_A), .NUM_PATTERNS(16), .MAX_LAT(8), .ERR_CNT_W(16)
    ) dut (
        .CLK(CLK), .resetn(resetn), .start(start), .lat_cfg(lat_cfg),
        .N1BEG(N1BEG), .N2BEG(N2BEG), .N2BEGb(N2BEGb), .N4BEG(N4BEG),
        .S1END(S1END), .S2MID(S2MID), .S2END(S2END), .S4END(S4END),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_pat(first_err_pat), .first_err_bit(first_err_bit)
    );

    s_term_loopback_checker #(
        .SEED(36'd0), .NUM_PATTERNS(32), .MAX_LAT(8), .ERR_CNT_W(4)
    ) dut2 (
        .CLK(CLK), .resetn(resetn), .start(start2), .lat_cfg(4'd1),
        .N1BEG(N1BEG2), .N2BEG(N2BEG2), .N2BEGb(N2BEGb2), .N4BEG(N4BEG2),
        .S1END(4'h0), .S2MID(8'h00), .S2END(8'h00), .S4END(16'h0000),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_err_pat(first_err_pat2), .first_err_bit(first_err_bit2)
    );

    // Loopback model: registered delay line, reflected per group
    logic [35:0] tx_cat, sel;
    logic [35:0] lb [8];
    logic [2:0]  msel = 3'd1;
    logic        stuck = 1'b0;

    assign tx_cat = {N4BEG, N2BEGb, N2BEG, N1BEG};

    always @(posedge CLK) begin
        lb[0] <= tx_cat;
        for (int i = 1; i < 8; i++) lb[i] <= lb[i-1];
    end

    always_comb begin
        sel = lb[msel];
        S1END = '0;
        S2MID = '0;
        S2END = '0;
        S4END = '0;
        for (int i = 0; i < 4; i++) S1END[3-i] = sel[i];
        for (int i = 0; i < 8; i++) begin
            S2MID[7-i] = sel[4+i];
            S2END[7-i] = sel[12+i];
        end
        for (int i = 0; i < 16; i++) S4END[15-i] = sel[20+i];
        if (stuck) S4END[15] = 1'b0;
    end

    logic [35:0] pat [16];

    function automatic logic [35:0] lstep(input logic [35:0] v);
        return {v[34:0], v[35] ^ v[24]};
    endfunction

    task automatic do_start;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        checks++;
        if ({tx_cat, busy, done, pass, err_cnt, first_err_pat,
             first_err_bit} !== '0) begin
            failures++;
            $display("FAIL reset_outputs tx=%h busy=%b done=%b err=%0d",
                     tx_cat, busy, done, err_cnt);
        end
    endtask

    task automatic test_pass_run;
        int cyc;
        msel = 3'd1; stuck = 1'b0; lat_cfg = 4'd2;
        do_start;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL run_busy busy=%b done=%b exp 1/0", busy, done);
        end
        checks++;
        if (tx_cat !== SEED_A) begin
            failures++;
            $display("FAIL first_tx got=%h exp=%h", tx_cat, SEED_A);
        end
        wait_done(0, cyc);
        checks++;
        if (cyc != 18) begin
            failures++;
            $display("FAIL pass_run_len got=%0d exp=18", cyc);
        end
        checks++;
        if (pass !== 1'b1 || err_cnt !== 16'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pass_run_result pass=%b err=%0d busy=%b exp 1/0/0",
                     pass, err_cnt, busy);
        end
    endtask

    task automatic test_stuck;
        int cyc, exp_err, exp_first;
        exp_err = 0; exp_first = -1;
        for (int k = 0; k < 16; k++)
            if (pat[k][20]) begin
                if (exp_first < 0) exp_first = k;
                exp_err++;
            end
        stuck = 1'b1;
        do_start;
        wait_done(0, cyc);
        stuck = 1'b0;
        checks++;
        if (err_cnt !== 16'(exp_err) || pass !== (exp_err == 0)) begin
            failures++;
            $display("FAIL stuck_err got=%0d pass=%b exp=%0d",
                     err_cnt, pass, exp_err);
        end
        checks++;
        if (first_err_bit !== 6'd20 || first_err_pat !== 16'(exp_first)) begin
            failures++;
            $display("FAIL stuck_first bit=%0d pat=%0d exp 20/%0d",
                     first_err_bit, first_err_pat, exp_first);
        end
    endtask

    task automatic test_wrong_lat;
        int cyc, exp_err, exp_bit;
        logic [35:0] prev;
        exp_err = 0; prev = '0; exp_bit = -1;
        for (int k = 0; k < 16; k++) begin
            if (pat[k] != prev) exp_err++;
            prev = pat[k];
        end
        for (int i = 35; i >= 0; i--) if (pat[0][i]) exp_bit = i;
        msel = 3'd2;
        do_start;
        wait_done(0, cyc);
        checks++;
        if (err_cnt !== 16'(exp_err) || pass !== 1'b0) begin
            failures++;
            $display("FAIL wrong_lat_err got=%0d pass=%b exp=%0d/0",
                     err_cnt, pass, exp_err);
        end
        checks++;
        if (first_err_pat !== 16'd0 || first_err_bit !== 6'(exp_bit)) begin
            failures++;
            $display("FAIL wrong_lat_first pat=%0d bit=%0d exp 0/%0d",
                     first_err_pat, first_err_bit, exp_bit);
        end
    endtask

    task automatic test_lat_bounds;
        int cyc;
        msel = 3'd0; lat_cfg = 4'd0;
        do_start;
        lat_cfg = 4'd2;
        wait_done(0, cyc);
        checks++;
        if (cyc != 17 || pass !== 1'b1) begin
            failures++;
            $display("FAIL lat_zero len=%0d pass=%b exp 17/1", cyc, pass);
        end
        msel = 3'd7; lat_cfg = 4'd15;
        do_start;
        lat_cfg = 4'd3;
        wait_done(0, cyc);
        checks++;
        if (cyc != 24 || pass !== 1'b1) begin
            failures++;
            $display("FAIL lat_clamp len=%0d pass=%b exp 24/1", cyc, pass);
        end
        lat_cfg = 4'd2;
        msel = 3'd1;
    endtask

    task automatic test_reset_abort;
        int cyc;
        msel = 3'd2;
        do_start;
        repeat (5) @(negedge CLK);
        resetn = 1'b0;
        #1;
        checks++;
        if ({tx_cat, busy, done, pass, err_cnt, first_err_pat,
             first_err_bit} !== '0) begin
            failures++;
            $display("FAIL abort_outputs tx=%h busy=%b err=%0d",
                     tx_cat, busy, err_cnt);
        end
        repeat (3) @(negedge CLK);
        resetn = 1'b1;
        msel = 3'd1;
        do_start;
        wait_done(0, cyc);
        checks++;
        if (cyc != 18 || pass !== 1'b1 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL abort_rerun len=%0d pass=%b err=%0d exp 18/1/0",
                     cyc, pass, err_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        for (int run = 0; run < 2; run++) begin
            do_start;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL b2b_done_drop run=%0d done=%b exp 0", run, done);
            end
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (tx_cat !== pat[k]) begin
                    failures++;
                    $display("FAIL b2b_tx run=%0d k=%0d got=%h exp=%h",
                             run, k, tx_cat, pat[k]);
                end
                start = (k == 5);
                @(negedge CLK);
            end
            start = 1'b0;
            wait_done(16, cyc);
            checks++;
            if (cyc != 18 || pass !== 1'b1) begin
                failures++;
                $display("FAIL b2b_result run=%0d len=%0d pass=%b exp 18/1",
                         run, cyc, pass);
            end
        end
    endtask

    task automatic test_saturate;
        int cyc;
        @(negedge CLK);
        start2 = 1'b1;
        @(negedge CLK);
        start2 = 1'b0;
        checks++;
        if ({N4BEG2, N2BEGb2, N2BEG2, N1BEG2} !== 36'd1) begin
            failures++;
            $display("FAIL zero_seed got=%h exp=1",
                     {N4BEG2, N2BEGb2, N2BEG2, N1BEG2});
        end
        cyc = 0;
        while (!done2 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (cyc != 33) begin
            failures++;
            $display("FAIL sat_len got=%0d exp=33", cyc);
        end
        checks++;
        if (err_cnt2 !== 4'd15 || pass2 !== 1'b0) begin
            failures++;
            $display("FAIL sat_err got=%0d pass=%b exp 15/0", err_cnt2, pass2);
        end
        checks++;
        if (first_err_pat2 !== 16'd0 || first_err_bit2 !== 6'd0) begin
            failures++;
            $display("FAIL sat_first pat=%0d bit=%0d exp 0/0",
                     first_err_pat2, first_err_bit2);
        end
    endtask

    initial begin
        pat[0] = SEED_A;
        for (int k = 1; k < 16; k++) pat[k] = lstep(pat[k-1]);
        test_reset;
        repeat (2) @(negedge CLK);
        resetn = 1'b1;
        repeat (2) @(negedge CLK);
        test_pass_run;
        test_stuck;
        test_wrong_lat;
        test_lat_bounds;
        test_reset_abort;
        test_back_to_back;
        test_saturate;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
